// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipe
//  Description : Pipeline control carrier for the 5-stage MIPS core. Carries
//                the decoder control word through ID/EX, EX/MEM and MEM/WB,
//                and resolves load-use stall, branch/jump flush and EX-stage
//                operand forwarding selects.
//  Options     : CTRL_PIPE_FWD_EN - when defined, EX operands are forwarded
//                from MEM/WB and only load-use hazards stall. When undefined,
//                fwd_a/fwd_b are tied to 00 and any RAW hazard against a
//                producer in EX or MEM stalls until it reaches WB.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
    parameter int SIG_W = 12,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [SIG_W-1:0] id_sig,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             ex_zero,
    output logic [SIG_W-1:0] ex_sig,
    output logic [SIG_W-1:0] mem_sig,
    output logic [SIG_W-1:0] wb_sig,
    output logic [REG_W-1:0] ex_rs,
    output logic [REG_W-1:0] ex_rt,
    output logic [REG_W-1:0] mem_dst,
    output logic [REG_W-1:0] wb_dst,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    // Control word bit positions (fixed by the decoder).
    localparam int C_BIT_INVBRANCH = 10;
    localparam int C_BIT_REGDST    = 8;
    localparam int C_BIT_MEMTOREG  = 6;
    localparam int C_BIT_WRITEREG  = 5;
    localparam int C_BIT_MEMWRITE  = 4;
    localparam int C_BIT_BRANCH    = 3;
    localparam int C_BIT_JUMP      = 0;

    // Operand select encodings.
    localparam logic [1:0] C_FWD_RF  = 2'b00;
    localparam logic [1:0] C_FWD_MEM = 2'b10;
    localparam logic [1:0] C_FWD_WB  = 2'b01;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic             r_ex_valid;
    logic [SIG_W-1:0] r_ex_sig;
    logic [REG_W-1:0] r_ex_rs;
    logic [REG_W-1:0] r_ex_rt;
    logic [REG_W-1:0] r_ex_dst;

    logic             r_mem_valid;
    logic [SIG_W-1:0] r_mem_sig;
    logic [REG_W-1:0] r_mem_dst;

    logic             r_wb_valid;
    logic [SIG_W-1:0] r_wb_sig;
    logic [REG_W-1:0] r_wb_dst;

    // ------------------------------------------------------------------
    // ID-side decode
    // ------------------------------------------------------------------
    // The ID word is only meaningful when valid and not being reset; this
    // keeps stall/flush at 0 while reset is asserted.
    logic             w_id_live;
    logic             w_id_uses_rt;
    logic [REG_W-1:0] w_id_dst;

    assign w_id_live    = rst_n & id_valid;
    assign w_id_uses_rt = id_sig[C_BIT_REGDST] | id_sig[C_BIT_BRANCH] | id_sig[C_BIT_MEMWRITE];
    assign w_id_dst     = id_sig[C_BIT_REGDST] ? id_rd : id_rt;

    // ------------------------------------------------------------------
    // Producer qualification: a stage writes a real register ($0 excluded)
    // ------------------------------------------------------------------
    logic w_ex_writes;
    logic w_mem_writes;
    logic w_ex_hits_id;

    assign w_ex_writes  = r_ex_valid  & r_ex_sig[C_BIT_WRITEREG]  & (r_ex_dst  != '0);
    assign w_mem_writes = r_mem_valid & r_mem_sig[C_BIT_WRITEREG] & (r_mem_dst != '0);

    // EX producer's destination is read by the ID instruction.
    assign w_ex_hits_id = w_ex_writes &
                          ((r_ex_dst == id_rs) | (w_id_uses_rt & (r_ex_dst == id_rt)));

    // ------------------------------------------------------------------
    // Branch resolution and jump
    // ------------------------------------------------------------------
    logic w_br_taken;
    logic w_jump;

    // BEQ takes on zero, BNE (InvBranch) takes on non-zero.
    assign w_br_taken = r_ex_valid & r_ex_sig[C_BIT_BRANCH] &
                        (ex_zero ^ r_ex_sig[C_BIT_INVBRANCH]);
    assign w_jump     = w_id_live & id_sig[C_BIT_JUMP];

    // ------------------------------------------------------------------
    // Hazard detection and forwarding
    // ------------------------------------------------------------------
    logic w_hazard;

`ifdef CTRL_PIPE_FWD_EN
    logic w_wb_writes;

    assign w_wb_writes = r_wb_valid & r_wb_sig[C_BIT_WRITEREG] & (r_wb_dst != '0);

    // Only a load in EX cannot be forwarded in time: its data exists after MEM.
    assign w_hazard = w_id_live & w_ex_hits_id & r_ex_sig[C_BIT_MEMTOREG];

    // Pick the youngest producer of src; MEM beats WB.
    function automatic logic [1:0] f_fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             mem_w,
        input logic [REG_W-1:0] mem_d,
        input logic             wb_w,
        input logic [REG_W-1:0] wb_d
    );
        logic [1:0] sel;
        sel = C_FWD_RF;
        if (mem_w && (mem_d == src)) begin
            sel = C_FWD_MEM;
        end else if (wb_w && (wb_d == src)) begin
            sel = C_FWD_WB;
        end
        return sel;
    endfunction

    // Operand selects for the EX sources.
    always_comb begin
        fwd_a = f_fwd_sel(r_ex_rs, w_mem_writes, r_mem_dst, w_wb_writes, r_wb_dst);
        fwd_b = f_fwd_sel(r_ex_rt, w_mem_writes, r_mem_dst, w_wb_writes, r_wb_dst);
    end
`else
    logic w_mem_hits_id;
    logic w_unused_wb;

    // Regfile is write-before-read, so a producer in WB no longer blocks ID.
    assign w_mem_hits_id = w_mem_writes &
                           ((r_mem_dst == id_rs) | (w_id_uses_rt & (r_mem_dst == id_rt)));
    assign w_hazard      = w_id_live & (w_ex_hits_id | w_mem_hits_id);
    assign w_unused_wb   = r_wb_valid;

    // No forwarding path: operands always come from the regfile.
    always_comb begin
        fwd_a = C_FWD_RF;
        fwd_b = C_FWD_RF;
    end
`endif

    // A taken branch kills the ID instruction, so a stall for it is moot.
    assign stall = w_hazard & ~w_br_taken;
    assign flush = w_br_taken | w_jump;

    // ID advances into EX only when it is real, not held, and not squashed.
    logic w_ex_load;
    assign w_ex_load = w_id_live & ~stall & ~w_br_taken;

    // ------------------------------------------------------------------
    // ID/EX register: capture the ID word or insert a bubble
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_sig   <= '0;
            r_ex_rs    <= '0;
            r_ex_rt    <= '0;
            r_ex_dst   <= '0;
        end else if (w_ex_load) begin
            r_ex_valid <= 1'b1;
            r_ex_sig   <= id_sig;
            r_ex_rs    <= id_rs;
            r_ex_rt    <= id_rt;
            r_ex_dst   <= w_id_dst;
        end else begin
            r_ex_valid <= 1'b0;
            r_ex_sig   <= '0;
            r_ex_rs    <= '0;
            r_ex_rt    <= '0;
            r_ex_dst   <= '0;
        end
    end

    // EX/MEM register: unconditional advance from EX
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_valid <= 1'b0;
            r_mem_sig   <= '0;
            r_mem_dst   <= '0;
        end else begin
            r_mem_valid <= r_ex_valid;
            r_mem_sig   <= r_ex_sig;
            r_mem_dst   <= r_ex_dst;
        end
    end

    // MEM/WB register: unconditional advance from MEM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_sig   <= '0;
            r_wb_dst   <= '0;
        end else begin
            r_wb_valid <= r_mem_valid;
            r_wb_sig   <= r_mem_sig;
            r_wb_dst   <= r_mem_dst;
        end
    end

    // ------------------------------------------------------------------
    // Per-stage control outputs (bubbles already carry all-zero fields)
    // ------------------------------------------------------------------
    assign ex_sig  = r_ex_sig;
    assign mem_sig = r_mem_sig;
    assign wb_sig  = r_wb_sig;
    assign ex_rs   = r_ex_rs;
    assign ex_rt   = r_ex_rt;
    assign mem_dst = r_mem_dst;
    assign wb_dst  = r_wb_dst;

endmodule
`default_nettype wire
